// File: rtl/bsg_downstream_in_rx_if.sv
// Handshake/bus bundle for the downstream link receiver.
// slave  : the receiver (consumes io beats and yumi, produces core/status signals)
// master : whatever drives the io link and consumes packets
interface bsg_downstream_in_rx_if #(
  parameter int FIFO_DEPTH = 64
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          io_valid_in;
  logic [7:0]    io_data_in_ch0;
  logic [7:0]    io_data_in_ch1;
  logic          io_token_out;
  logic          core_valid_out;
  logic [63:0]   core_data_out;
  logic          core_yumi_in;
  logic [CW-1:0] fifo_count_out;
  logic          overflow_out;
  logic          timeout_out;

  modport master (
    output io_valid_in, io_data_in_ch0, io_data_in_ch1, core_yumi_in,
    input  io_token_out, core_valid_out, core_data_out, fifo_count_out,
           overflow_out, timeout_out
  );

  modport slave (
    input  io_valid_in, io_data_in_ch0, io_data_in_ch1, core_yumi_in,
    output io_token_out, core_valid_out, core_data_out, fifo_count_out,
           overflow_out, timeout_out
  );
endinterface

// File: rtl/bsg_downstream_in_rx.sv
// Receive end of the off-chip upstream link: gathers 4 two-byte io beats
// into a 64-bit packet, queues packets in a credit-sized FIFO with a
// first-word-fall-through head, and returns io tokens as the core consumes.
// Optional partial-packet timeout: define BSG_DS_RX_TIMEOUT_EN.
module bsg_downstream_in_rx #(
  parameter int FIFO_DEPTH  = 64,
  parameter int TOKEN_BATCH = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  bsg_downstream_in_rx_if.slave        bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (TOKEN_BATCH > 1) ? $clog2(TOKEN_BATCH) : 1;

  // Drop one beat's two bytes into their packet lanes.
  function automatic logic [63:0] place_beat(input logic [63:0] pkt,
                                             input logic [1:0]  b,
                                             input logic [7:0]  c0,
                                             input logic [7:0]  c1);
    logic [63:0] r;
    r = pkt;
    case (b)
      2'd0:    begin r[7:0]   = c0; r[23:16] = c1; end
      2'd1:    begin r[15:8]  = c0; r[31:24] = c1; end
      2'd2:    begin r[39:32] = c0; r[55:48] = c1; end
      default: begin r[47:40] = c0; r[63:56] = c1; end
    endcase
    return r;
  endfunction

  logic [1:0]    beat_q, beat_d;
  logic [63:0]   asm_q, asm_d;
  logic [63:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic [BW-1:0] batch_q, batch_d;
  logic          token_q, token_d;
  logic          overflow_q, overflow_d;
  logic [63:0]   hold_q;
  logic          push, pop, full, wr_en;

`ifdef BSG_DS_RX_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  logic [IW-1:0] idle_q, idle_d;
  logic          timeout_q, timeout_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYC;
`endif

  assign full = (count_q == CW'(FIFO_DEPTH));
  assign pop  = bus.core_yumi_in && (count_q != '0);

  // Beat assembly, partial-packet timeout, FIFO bookkeeping and token batching.
  always_comb begin
    beat_d     = beat_q;
    asm_d      = asm_q;
    push       = 1'b0;
    wr_d       = wr_q;
    rd_d       = rd_q;
    count_d    = count_q;
    batch_d    = batch_q;
    token_d    = 1'b0;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
`ifdef BSG_DS_RX_TIMEOUT_EN
    idle_d     = idle_q;
    timeout_d  = timeout_q;
`endif

    if (bus.io_valid_in) begin
      asm_d  = place_beat(asm_q, beat_q, bus.io_data_in_ch0, bus.io_data_in_ch1);
      push   = (beat_q == 2'd3);
      beat_d = beat_q + 2'd1;
    end

`ifdef BSG_DS_RX_TIMEOUT_EN
    // The idle counter only runs while a packet is partially assembled; the
    // cycle that would carry it to TIMEOUT_CYC abandons the partial packet.
    if (bus.io_valid_in || beat_q == 2'd0) begin
      idle_d = '0;
    end else if (idle_q == IW'(TIMEOUT_CYC - 1)) begin
      idle_d    = '0;
      beat_d    = 2'd0;
      timeout_d = 1'b1;
    end else begin
      idle_d = idle_q + IW'(1);
    end
`endif

    // A pop frees a slot in the same cycle, so full+push+pop is accepted.
    wr_en = push && (!full || pop);
    if (push && full && !pop) overflow_d = 1'b1;

    if (wr_en) wr_d = wr_q + PW'(1);
    if (pop)   rd_d = rd_q + PW'(1);

    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (pop) begin
      if (batch_q == BW'(TOKEN_BATCH - 1)) begin
        batch_d = '0;
        token_d = 1'b1;
      end else begin
        batch_d = batch_q + BW'(1);
      end
    end
  end

  // Control state; reset drops any partial packet and all queued packets.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q     <= 2'd0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      batch_q    <= '0;
      token_q    <= 1'b0;
      overflow_q <= 1'b0;
      hold_q     <= '0;
`ifdef BSG_DS_RX_TIMEOUT_EN
      idle_q     <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      beat_q     <= beat_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      batch_q    <= batch_d;
      token_q    <= token_d;
      overflow_q <= overflow_d;
      if (count_q != '0) hold_q <= mem_q[rd_q];
`ifdef BSG_DS_RX_TIMEOUT_EN
      idle_q     <= idle_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  // Datapath storage: assembly register and packet slots, never reset.
  always_ff @(posedge clk) begin
    asm_q <= asm_d;
    if (wr_en) mem_q[wr_q] <= asm_d;
  end

  assign bus.io_token_out   = token_q;
  assign bus.core_valid_out = (count_q != '0);
  // While empty, the last head presented stays on the bus.
  assign bus.core_data_out  = (count_q != '0) ? mem_q[rd_q] : hold_q;
  assign bus.fifo_count_out = count_q;
  assign bus.overflow_out   = overflow_q;
`ifdef BSG_DS_RX_TIMEOUT_EN
  assign bus.timeout_out    = timeout_q;
`else
  assign bus.timeout_out    = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_downstream_in_rx.sv
// Bench for bsg_downstream_in_rx: two instances (depth 4 / batch 1 and
// depth 16 / batch 4) share the io link; each has its own yumi. A queue-based
// reference model is updated at every posedge and compared at every negedge.
module tb_bsg_downstream_in_rx;

  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       io_v = 1'b0;
  logic [7:0] c0 = '0, c1 = '0;
  logic       ya = 1'b0, yb = 1'b0;

  bsg_downstream_in_rx_if #(.FIFO_DEPTH(4))  ifa ();
  bsg_downstream_in_rx_if #(.FIFO_DEPTH(16)) ifb ();

  assign ifa.io_valid_in    = io_v;
  assign ifa.io_data_in_ch0 = c0;
  assign ifa.io_data_in_ch1 = c1;
  assign ifa.core_yumi_in   = ya;
  assign ifb.io_valid_in    = io_v;
  assign ifb.io_data_in_ch0 = c0;
  assign ifb.io_data_in_ch1 = c1;
  assign ifb.core_yumi_in   = yb;

  bsg_downstream_in_rx #(.FIFO_DEPTH(4), .TOKEN_BATCH(1), .TIMEOUT_CYC(TMO))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  bsg_downstream_in_rx #(.FIFO_DEPTH(16), .TOKEN_BATCH(4), .TIMEOUT_CYC(TMO))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [63:0] mq [2][$];
  int          depth [2] = '{4, 16};
  int          tbat  [2] = '{1, 4};
  int          pops  [2];
  bit          m_ovf [2];
  bit          m_tok [2];
  logic [63:0] m_last [2];
  logic [15:0] pb [$];
  int          m_idle;
  bit          m_tmo;
  int          lane0 [4] = '{0, 1, 4, 5};
  int          lane1 [4] = '{2, 3, 6, 7};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] build_pkt();
    logic [63:0] p;
    p = '0;
    for (int b = 0; b < 4; b++) begin
      p[8*lane0[b] +: 8] = pb[b][15:8];
      p[8*lane1[b] +: 8] = pb[b][7:0];
    end
    return p;
  endfunction

  // Advance the model by one clock edge using the inputs presented this cycle.
  task automatic model_step();
    logic [63:0] pkt;
    bit          push;
    bit          y [2];
    y[0] = ya; y[1] = yb;
    push = 1'b0;
    pkt  = '0;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        mq[k].delete(); pops[k] = 0; m_ovf[k] = 0; m_tok[k] = 0; m_last[k] = '0;
      end
      pb.delete(); m_idle = 0; m_tmo = 0;
      return;
    end
    if (io_v) begin
      pb.push_back({c0, c1});
      m_idle = 0;
      if (pb.size() == 4) begin
        pkt = build_pkt();
        push = 1'b1;
        pb.delete();
      end
    end else if (pb.size() != 0) begin
`ifdef BSG_DS_RX_TIMEOUT_EN
      m_idle++;
      if (m_idle == TMO) begin
        pb.delete(); m_idle = 0; m_tmo = 1;
      end
`endif
    end
    for (int k = 0; k < 2; k++) begin
      m_tok[k] = 0;
      if (y[k] && mq[k].size() > 0) begin
        void'(mq[k].pop_front());
        pops[k]++;
        if (pops[k] % tbat[k] == 0) m_tok[k] = 1;
      end
      if (push) begin
        if (mq[k].size() < depth[k]) mq[k].push_back(pkt);
        else m_ovf[k] = 1;
      end
    end
  endtask

  task automatic check_dut(input int k);
    logic        v, t, o, tm;
    logic [63:0] d, c, exp_d;
    string       nm;
    if (k == 0) begin
      nm = "A"; v = ifa.core_valid_out; t = ifa.io_token_out; o = ifa.overflow_out;
      tm = ifa.timeout_out; d = ifa.core_data_out; c = 64'(ifa.fifo_count_out);
    end else begin
      nm = "B"; v = ifb.core_valid_out; t = ifb.io_token_out; o = ifb.overflow_out;
      tm = ifb.timeout_out; d = ifb.core_data_out; c = 64'(ifb.fifo_count_out);
    end
    exp_d = (mq[k].size() > 0) ? mq[k][0] : m_last[k];
    m_last[k] = exp_d;
    chk({nm, ".valid"},    64'(v),  64'(mq[k].size() > 0));
    chk({nm, ".count"},    c,       64'(mq[k].size()));
    chk({nm, ".data"},     d,       exp_d);
    chk({nm, ".overflow"}, 64'(o),  64'(m_ovf[k]));
    chk({nm, ".token"},    64'(t),  64'(m_tok[k]));
`ifdef BSG_DS_RX_TIMEOUT_EN
    chk({nm, ".timeout"},  64'(tm), 64'(m_tmo));
`else
    chk({nm, ".timeout"},  64'(tm), 64'd0);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_dut(0);
    check_dut(1);
  endtask

  // Present inputs for the next edge; yumi only while the model has data.
  task automatic drive(input bit v, input logic [7:0] d0, input logic [7:0] d1,
                       input bit wa, input bit wb);
    io_v = v; c0 = d0; c1 = d1;
    ya = wa && (mq[0].size() > 0);
    yb = wb && (mq[1].size() > 0);
  endtask

  task automatic beat(input logic [7:0] d0, input logic [7:0] d1, input bit wa, input bit wb);
    drive(1'b1, d0, d1, wa, wb);
    step();
  endtask

  task automatic idle(input int n, input bit wa, input bit wb);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 8'h00, 8'h00, wa, wb);
      step();
    end
  endtask

  task automatic rand_pkt(input bit wa, input bit wb);
    for (int i = 0; i < 4; i++) beat(8'($urandom), 8'($urandom), wa, wb);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(1, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  int pulses;

  initial begin
    // Reset state
    rst = 1'b1;
    idle(2, 1'b0, 1'b0);
    rst = 1'b0;
    chk("reset.data", ifa.core_data_out, 64'd0);

    // Single packet, consecutive beats
    beat(8'h01, 8'h05, 0, 0);
    beat(8'h02, 8'h06, 0, 0);
    beat(8'h03, 8'h07, 0, 0);
    beat(8'h04, 8'h08, 0, 0);
    chk("single.valid", 64'(ifa.core_valid_out), 64'd1);
    chk("single.data",  ifa.core_data_out, 64'h0807_0403_0605_0201);
    idle(1, 1, 1);
    chk("single.token", 64'(ifa.io_token_out), 64'd1);
    chk("single.count", 64'(ifa.fifo_count_out), 64'd0);
    idle(1, 0, 0);

    // Gapped beats
    do_reset();
    beat(8'h01, 8'h05, 0, 0); idle(3, 0, 0);
    beat(8'h02, 8'h06, 0, 0); idle(3, 0, 0);
    beat(8'h03, 8'h07, 0, 0); idle(3, 0, 0);
    chk("gapped.valid_early", 64'(ifa.core_valid_out), 64'd0);
    beat(8'h04, 8'h08, 0, 0);
    chk("gapped.data", ifa.core_data_out, 64'h0807_0403_0605_0201);
    idle(2, 1, 1);

    // Fill and overflow on the depth-4 instance
    do_reset();
    for (int p = 0; p < 5; p++) rand_pkt(0, 0);
    chk("fill.count", 64'(ifa.fifo_count_out), 64'd4);
    chk("fill.overflow", 64'(ifa.overflow_out), 64'd1);
    do_reset();
    for (int p = 0; p < 4; p++) rand_pkt(0, 0);
    for (int i = 0; i < 3; i++) beat(8'($urandom), 8'($urandom), 0, 0);
    beat(8'hA5, 8'h5A, 1, 0);
    chk("fullpop.overflow", 64'(ifa.overflow_out), 64'd0);
    chk("fullpop.count", 64'(ifa.fifo_count_out), 64'd4);
    idle(6, 1, 1);

    // Token batching on the batch-4 instance
    do_reset();
    for (int p = 0; p < 10; p++) rand_pkt(0, 0);
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      idle(1, 1, 1);
      if (ifb.io_token_out === 1'b1) pulses++;
    end
    chk("batch.pulses", 64'(pulses), 64'd2);

    // Reset mid-operation
    do_reset();
    for (int p = 0; p < 3; p++) rand_pkt(0, 0);
    beat(8'h77, 8'h88, 0, 0);
    beat(8'h99, 8'hAA, 0, 0);
    do_reset();
    chk("midrst.count", 64'(ifb.fifo_count_out), 64'd0);
    chk("midrst.data",  ifb.core_data_out, 64'd0);
    beat(8'h11, 8'h15, 0, 0);
    beat(8'h12, 8'h16, 0, 0);
    beat(8'h13, 8'h17, 0, 0);
    beat(8'h14, 8'h18, 0, 0);
    chk("midrst.head", ifb.core_data_out, 64'h1817_1413_1615_1211);
    idle(2, 1, 1);

`ifdef BSG_DS_RX_TIMEOUT_EN
    // Partial-packet timeout
    do_reset();
    beat(8'h21, 8'h22, 0, 0);
    beat(8'h23, 8'h24, 0, 0);
    idle(TMO, 0, 0);
    chk("tmo.flag", 64'(ifa.timeout_out), 64'd1);
    chk("tmo.count", 64'(ifa.fifo_count_out), 64'd0);
    beat(8'h01, 8'h05, 0, 0);
    beat(8'h02, 8'h06, 0, 0);
    beat(8'h03, 8'h07, 0, 0);
    beat(8'h04, 8'h08, 0, 0);
    chk("tmo.data", ifa.core_data_out, 64'h0807_0403_0605_0201);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 9) < 6, 8'($urandom), 8'($urandom),
              $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
